// File: rtl/mem_responder_if.sv
// Request/response bundle between the control unit and mem_responder.
// master: control unit drives Read/Write/MAR/MDR; slave: responder drives Mdatain/Done/Busy/Err.
interface mem_responder_if;
  logic        Read;
  logic        Write;
  logic [31:0] MAR_output;
  logic [31:0] MDR_output;
  logic [31:0] Mdatain;
  logic        Done;
  logic        Busy;
  logic        Err;

  modport master (
    output Read,
    output Write,
    output MAR_output,
    output MDR_output,
    input  Mdatain,
    input  Done,
    input  Busy,
    input  Err
  );

  modport slave (
    input  Read,
    input  Write,
    input  MAR_output,
    input  MDR_output,
    output Mdatain,
    output Done,
    output Busy,
    output Err
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: wait-stated single-port 32-bit word RAM behind MAR/MDR.
// Ports: clock, clear (async active-low), bus (slave: Read/Write/MAR/MDR in; Mdatain/Done/Busy/Err out).
module mem_responder #(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_CYCLES = 2
) (
  input logic            clock,
  input logic            clear,
  mem_responder_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // WAIT always holds for WAIT_CYCLES+1 cycles, so Done lands
  // WAIT_CYCLES+1 edges after the accepting edge, even at zero.
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic                  op_wr;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;

  logic [31:0] mdatain_q;
  logic        done_q;
  logic        busy_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  logic req_rd;
  logic req_wr;
  logic req_both;
  logic commit;

  assign req_rd   = bus.Read & ~bus.Write;
  assign req_wr   = bus.Write & ~bus.Read;
  assign req_both = bus.Read & bus.Write;
  assign commit   = (state == S_WAIT) && (cnt == 4'd0);

  logic unused_mar;
  assign unused_mar = ^bus.MAR_output[31:ADDR_WIDTH];

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      op_wr     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      mdatain_q <= 32'h0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          unique case (1'b1)
            req_both: err_q <= 1'b1;
            req_rd, req_wr: begin
              state   <= S_WAIT;
              cnt     <= WAIT_LD;
              op_wr   <= req_wr;
              addr_q  <= bus.MAR_output[ADDR_WIDTH-1:0];
              wdata_q <= bus.MDR_output;
              busy_q  <= 1'b1;
            end
            default: ;
          endcase
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state  <= S_RESP;
            done_q <= 1'b1;
            if (!op_wr)
              mdatain_q <= mem[addr_q];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // RAM is not reset; an abort leaves state in IDLE so commit is low.
  always_ff @(posedge clock) begin
    if (commit && op_wr)
      mem[addr_q] <= wdata_q;
  end

  assign bus.Mdatain = mdatain_q;
  assign bus.Done    = done_q;
  assign bus.Busy    = busy_q;
  assign bus.Err     = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed plan steps plus random ops against a word-array model.
// Two instances: WAIT_CYCLES=2 (sel 0) and WAIT_CYCLES=0 (sel 1).
module tb_mem_responder;

  logic clk = 1'b0;
  logic clear2;
  logic clear0;

  always #5 clk = ~clk;

  mem_responder_if b2 ();
  mem_responder_if b0 ();

  mem_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(2)) dut2 (
    .clock(clk),
    .clear(clear2),
    .bus  (b2)
  );

  mem_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(0)) dut0 (
    .clock(clk),
    .clear(clear0),
    .bus  (b0)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mm  [2][512];
  bit          vld [2][512];
  logic [31:0] md  [2];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      b2.Read = rd; b2.Write = wr; b2.MAR_output = a; b2.MDR_output = d;
    end else begin
      b0.Read = rd; b0.Write = wr; b0.MAR_output = a; b0.MDR_output = d;
    end
  endtask

  function automatic logic [31:0] g_mdat(input int sel);
    return (sel == 0) ? b2.Mdatain : b0.Mdatain;
  endfunction

  function automatic logic g_done(input int sel);
    return (sel == 0) ? b2.Done : b0.Done;
  endfunction

  function automatic logic g_busy(input int sel);
    return (sel == 0) ? b2.Busy : b0.Busy;
  endfunction

  function automatic logic g_err(input int sel);
    return (sel == 0) ? b2.Err : b0.Err;
  endfunction

  // One full handshake: raise request, wait for Done, drop, confirm idle.
  task automatic access(input int sel, input bit rd, input logic [31:0] a,
                        input logic [31:0] d, input bit scramble);
    int w;
    int cyc;
    bit seen;
    logic [8:0] ix;
    w = (sel == 0) ? 2 : 0;
    cyc = 0;
    seen = 0;
    ix = a[8:0];
    drive(sel, rd, !rd, a, d);
    while (!seen && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      seen = g_done(sel);
      if (!seen && scramble)
        drive(sel, rd, !rd, $urandom, $urandom);
    end
    if (rd) begin
      md[sel] = mm[sel][ix];
    end else begin
      mm[sel][ix] = d;
      vld[sel][ix] = 1'b1;
    end
    check(rd ? "rd_latency" : "wr_latency", cyc, w + 2);
    check("busy_at_done", {31'd0, g_busy(sel)}, 32'd1);
    check("mdat_at_done", g_mdat(sel), md[sel]);
    drive(sel, 1'b0, 1'b0, a, d);
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, g_done(sel)}, 32'd0);
    check("busy_after", {31'd0, g_busy(sel)}, 32'd0);
    check("mdat_hold", g_mdat(sel), md[sel]);
  endtask

  initial begin
    int gap;
    int cyc;
    bit seen;
    md[0] = 32'h0;
    md[1] = 32'h0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 512; i++) begin
        vld[s][i] = 1'b0;
        mm[s][i]  = 32'h0;
      end
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    clear2 = 1'b0;
    clear0 = 1'b0;
    #22;
    for (int s = 0; s < 2; s++) begin
      check("rst_mdat", g_mdat(s), 32'h0);
      check("rst_done", {31'd0, g_done(s)}, 32'd0);
      check("rst_busy", {31'd0, g_busy(s)}, 32'd0);
      check("rst_err", {31'd0, g_err(s)}, 32'd0);
    end
    clear2 = 1'b1;
    clear0 = 1'b1;
    @(posedge clk); #1;

    access(0, 0, 32'h012, 32'hDEADBEEF, 0);
    access(0, 1, 32'h012, 32'h0, 0);
    check("rd_deadbeef", g_mdat(0), 32'hDEADBEEF);

    access(0, 0, 32'h212, 32'h00000055, 0);
    access(0, 1, 32'h012, 32'h0, 0);
    check("alias_rd", g_mdat(0), 32'h00000055);

    drive(0, 1, 1, 32'h012, 32'hFFFFFFFF);
    @(posedge clk); #1;
    check("err_pulse", {31'd0, g_err(0)}, 32'd1);
    check("err_no_done", {31'd0, g_done(0)}, 32'd0);
    check("err_no_busy", {31'd0, g_busy(0)}, 32'd0);
    drive(0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("err_clears", {31'd0, g_err(0)}, 32'd0);
    access(0, 1, 32'h012, 32'h0, 0);
    check("err_ram_same", g_mdat(0), 32'h00000055);

    access(0, 0, 32'h020, 32'hAAAAAAAA, 0);
    drive(0, 0, 1, 32'h020, 32'h12345678);
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear2 = 1'b0;
    #1;
    md[0] = 32'h0;
    check("abort_mdat", g_mdat(0), 32'h0);
    check("abort_done", {31'd0, g_done(0)}, 32'd0);
    check("abort_busy", {31'd0, g_busy(0)}, 32'd0);
    drive(0, 0, 0, 0, 0);
    #2;
    clear2 = 1'b1;
    @(posedge clk); #1;
    access(0, 1, 32'h020, 32'h0, 0);
    check("abort_kept", g_mdat(0), 32'hAAAAAAAA);

    access(0, 0, 32'h0C3, 32'h0BADF00D, 1);
    access(0, 1, 32'h0C3, 32'h0, 1);
    check("latched_vals", g_mdat(0), 32'h0BADF00D);

    access(1, 0, 32'h001, 32'h11111111, 0);
    access(1, 0, 32'h002, 32'h22222222, 0);
    drive(1, 1, 0, 32'h001, 32'h0);
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      seen = g_done(1);
    end
    check("b2b_first_lat", cyc, 2);
    check("b2b_first", g_mdat(1), 32'h11111111);
    drive(1, 1, 0, 32'h002, 32'h0);
    gap = 0;
    seen = 0;
    while (!seen && gap < 64) begin
      @(posedge clk); #1;
      gap++;
      seen = g_done(1);
    end
    check("b2b_gap", gap, 3);
    check("b2b_second", g_mdat(1), 32'h22222222);
    md[1] = 32'h22222222;
    drive(1, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("b2b_idle", {31'd0, g_busy(1)}, 32'd0);

    for (int n = 0; n < 24; n++) begin
      int s;
      bit rd;
      logic [31:0] a;
      s  = int'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      a  = $urandom;
      if (rd && !vld[s][a[8:0]])
        rd = 1'b0;
      access(s, rd, a, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
